// File: rtl/pwm_carrier_gen_pkg.sv
// Shared PWM types: on/off control, carrier mode and carrier direction.
// CARR_WIDTH keeps the carrier width identical across all channels.
`ifndef CARR_WIDTH
`define CARR_WIDTH 16
`endif

package pwm_carrier_gen_pkg;

  typedef enum logic {
    PWM_OFF = 1'b0,
    PWM_ON  = 1'b1
  } _pwm_onoff;

  typedef enum logic {
    CARR_SAW = 1'b0,
    CARR_TRI = 1'b1
  } _carr_mode;

  typedef enum logic {
    CARR_UP   = 1'b0,
    CARR_DOWN = 1'b1
  } _carr_dir;

endpackage

// File: rtl/pwm_carrier_gen.sv
// Sawtooth/triangle carrier counter with zero/peak event pulses.
// Period and mode are shadowed and only take effect when the carrier returns to zero.
module pwm_carrier_gen
  import pwm_carrier_gen_pkg::*;
#(
  parameter int CNT_W = `CARR_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  _pwm_onoff        pwm_onoff,
  input  logic             tick,
  input  logic [CNT_W-1:0] period,
  input  _carr_mode        mode,
  input  logic [CNT_W-1:0] phase,
  input  _carr_dir         phase_dir,
  output logic [CNT_W-1:0] carrier,
  output _carr_dir         dir,
  output logic             zero_evt,
  output logic             peak_evt
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] carrier_reg, carrier_next;
  _carr_dir         dir_reg, dir_next;
  logic [CNT_W-1:0] p_act_reg, p_act_next;
  _carr_mode        m_act_reg, m_act_next;
  logic             zero_reg, zero_next;
  logic             peak_reg, peak_next;

  always_comb begin
    carrier_next = carrier_reg;
    dir_next     = dir_reg;
    p_act_next   = p_act_reg;
    m_act_next   = m_act_reg;
    zero_next    = 1'b0;
    peak_next    = 1'b0;

    if (pwm_onoff == PWM_OFF) begin
      p_act_next   = period;
      m_act_next   = mode;
      carrier_next = (phase > period) ? period : phase;
      dir_next     = (mode == CARR_TRI) ? phase_dir : CARR_UP;
    end else if (tick) begin
      if (m_act_reg == CARR_SAW) begin
        carrier_next = (carrier_reg >= p_act_reg) ? '0 : carrier_reg + ONE;
      end else if (dir_reg == CARR_UP) begin
        // A zero-length triangle must not underflow at P_act-1.
        if (p_act_reg == '0) begin
          carrier_next = '0;
        end else if (carrier_reg >= p_act_reg) begin
          carrier_next = p_act_reg - ONE;
          dir_next     = CARR_DOWN;
        end else begin
          carrier_next = carrier_reg + ONE;
          if (carrier_reg + ONE == p_act_reg) begin
            dir_next = CARR_DOWN;
          end
        end
      end else begin
        if (carrier_reg <= ONE) begin
          carrier_next = '0;
          dir_next     = CARR_UP;
        end else begin
          carrier_next = carrier_reg - ONE;
        end
      end

      zero_next = (carrier_next == '0);
      peak_next = (carrier_next == p_act_reg) && (p_act_reg != '0);

      if (zero_next) begin
        p_act_next = period;
        m_act_next = mode;
        if (mode == CARR_SAW) begin
          dir_next = CARR_UP;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      carrier_reg <= '0;
      dir_reg     <= CARR_UP;
      p_act_reg   <= '0;
      m_act_reg   <= CARR_SAW;
      zero_reg    <= 1'b0;
      peak_reg    <= 1'b0;
    end else begin
      carrier_reg <= carrier_next;
      dir_reg     <= dir_next;
      p_act_reg   <= p_act_next;
      m_act_reg   <= m_act_next;
      zero_reg    <= zero_next;
      peak_reg    <= peak_next;
    end
  end

  assign carrier  = carrier_reg;
  assign dir      = dir_reg;
  assign zero_evt = zero_reg;
  assign peak_evt = peak_reg;

endmodule
